// File: rtl/mp_csa_pkg.sv
// Shared FSM encoding and chunk-count helper for the carry-save accumulator.
package mp_csa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_SUB     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Number of CHUNK-wide slices covering the WIDTH+2 bit redundant accumulator.
  function automatic int nchunk(input int width, input int chunk);
    return (width + 2 + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/csa4to2.sv
// One-bit 4:2 compressor: a+b+c+d+cin = sum + 2*(carry+cout); cout is independent of cin.
module csa4to2 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  input  logic cin_i,
  output logic sum_o,
  output logic carry_o,
  output logic cout_o
);

  logic s1;

  assign s1      = a_i ^ b_i ^ c_i;
  assign cout_o  = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign sum_o   = s1 ^ d_i ^ cin_i;
  assign carry_o = (s1 & d_i) | (s1 & cin_i) | (d_i & cin_i);

endmodule

// File: rtl/mp_csa_acc.sv
// Carry-save halving accumulator with chunked carry resolution; MP_CSA_ACC_FINAL_SUB_EN adds a final conditional subtract.
// Steps take one cycle; result valid NCHUNK (2*NCHUNK with subtract) cycles after resolve, held until res_ready.
module mp_csa_acc
  import mp_csa_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int CHUNK = 128
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             cs_lsb,
  input  logic             clear,
  input  logic             resolve,
  input  logic [WIDTH-1:0] modulus,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  localparam int AW  = WIDTH + 2;
  localparam int NCH = nchunk(WIDTH, CHUNK);
  localparam int PW  = NCH * CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  state_t                       state_q, state_d;
  logic [AW-1:0]                s_q, s_d, cy_q, cy_d;
  logic [NCH-1:0][CHUNK-1:0]    r_q, r_d;
  logic [KW-1:0]                k_q, k_d;
  logic                         carry_q, carry_d;

  // 4:2 compression of S + Cy + b + m; the >>1 is pure rewiring.
  logic [AW-1:0] b_ext, m_ext, cmp_sum, cmp_carry, cmp_cout, cmp_cin;
  logic [AW-1:0] s_step, cy_step;

  assign b_ext   = AW'(b_in);
  assign m_ext   = AW'(m_in);
  assign cmp_cin = {cmp_cout[AW-2:0], 1'b0};

  for (genvar i = 0; i < AW; i++) begin : g_csa
    csa4to2 u_csa (
      .a_i     (s_q[i]),
      .b_i     (cy_q[i]),
      .c_i     (b_ext[i]),
      .d_i     (m_ext[i]),
      .cin_i   (cmp_cin[i]),
      .sum_o   (cmp_sum[i]),
      .carry_o (cmp_carry[i]),
      .cout_o  (cmp_cout[i])
    );
  end

  assign s_step  = {1'b0, cmp_sum[AW-1:1]};
  assign cy_step = cmp_carry;

  logic [NCH-1:0][CHUNK-1:0] s_chk, cy_chk;
  logic [PW-1:0]             r_flat;
  logic [CHUNK:0]            add_w;

  assign s_chk  = PW'(s_q);
  assign cy_chk = PW'(cy_q);
  assign r_flat = r_q;
  assign add_w  = {1'b0, s_chk[k_q]} + {1'b0, cy_chk[k_q]} + {{CHUNK{1'b0}}, carry_q};

`ifdef MP_CSA_ACC_FINAL_SUB_EN
  logic [NCH-1:0][CHUNK-1:0] d_q, d_d, mod_chk;
  logic [PW-1:0]             d_flat;
  logic                      borrow_q, borrow_d;
  logic [CHUNK:0]            sub_w;
  logic                      unused_bits;

  assign mod_chk = PW'(modulus);
  assign d_flat  = d_q;
  // A set top bit of the CHUNK+1 wide difference means this slice went negative.
  assign sub_w   = {1'b0, r_q[k_q]} - {1'b0, mod_chk[k_q]} - {{CHUNK{1'b0}}, borrow_q};
  assign unused_bits = ^{cmp_sum[0], cmp_cout[AW-1], r_flat[PW-1:WIDTH+1], d_flat[PW-1:WIDTH+1]};
  assign result  = (state_q == ST_DONE) ? (borrow_q ? r_flat[WIDTH:0] : d_flat[WIDTH:0]) : '0;
`else
  logic unused_bits;

  assign unused_bits = ^{modulus, cmp_sum[0], cmp_cout[AW-1], r_flat[PW-1:WIDTH+1]};
  assign result      = (state_q == ST_DONE) ? r_flat[WIDTH:0] : '0;
`endif

  assign step_ready = (state_q == ST_IDLE) && !clear && !resolve;
  assign cs_lsb     = s_q[0] ^ cy_q[0] ^ b_in[0];
  assign res_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cy_d    = cy_q;
    r_d     = r_q;
    k_d     = k_q;
    carry_d = carry_q;
`ifdef MP_CSA_ACC_FINAL_SUB_EN
    d_d      = d_q;
    borrow_d = borrow_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          s_d  = '0;
          cy_d = '0;
        end else if (resolve) begin
          state_d = ST_RESOLVE;
          k_d     = '0;
          carry_d = 1'b0;
        end else if (step_valid) begin
          s_d  = s_step;
          cy_d = cy_step;
        end
      end
      ST_RESOLVE: begin
        r_d[k_q] = add_w[CHUNK-1:0];
        carry_d  = add_w[CHUNK];
        k_d      = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d = '0;
`ifdef MP_CSA_ACC_FINAL_SUB_EN
          state_d  = ST_SUB;
          borrow_d = 1'b0;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef MP_CSA_ACC_FINAL_SUB_EN
      ST_SUB: begin
        d_d[k_q] = sub_w[CHUNK-1:0];
        borrow_d = sub_w[CHUNK];
        k_d      = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          s_d     = '0;
          cy_d    = '0;
          r_d     = '0;
          k_d     = '0;
          carry_d = 1'b0;
`ifdef MP_CSA_ACC_FINAL_SUB_EN
          d_d      = '0;
          borrow_d = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      cy_q    <= '0;
      r_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
`ifdef MP_CSA_ACC_FINAL_SUB_EN
      d_q      <= '0;
      borrow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cy_q    <= cy_d;
      r_q     <= r_d;
      k_q     <= k_d;
      carry_q <= carry_d;
`ifdef MP_CSA_ACC_FINAL_SUB_EN
      d_q      <= d_d;
      borrow_q <= borrow_d;
`endif
    end
  end

endmodule

// File: doc/mp_csa_acc.md
MP_CSA_ACC -- requirements
Module: mp_csa_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 512, operand/modulus width in bits (>=8).
REQ-002 SHALL have parameter CHUNK, default 128, carry-propagate slice width (4..WIDTH).
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports step_valid in 1 and step_ready out 1: accumulate-step handshake.
REQ-006 SHALL have ports b_in in WIDTH and m_in in WIDTH: step addends.
REQ-007 SHALL have port cs_lsb  out  1  = S[0]^Cy[0]^b_in[0] (combinational, for quotient-bit selection).
REQ-008 SHALL have ports clear in 1 (zero accumulator) and resolve in 1 (start carry resolution).
REQ-009 SHALL have port modulus  in  WIDTH  subtrahend for final reduction, stable from resolve until res_valid.
REQ-010 SHALL have ports res_valid out 1, res_ready in 1, result out WIDTH+1, busy out 1.

Function
REQ-011 SHALL hold accumulator as redundant pair S, Cy, each WIDTH+2 bits; value V=S+Cy.
REQ-012 SHALL define NCHUNK = ceil((WIDTH+2)/CHUNK); last chunk zero-extended.
REQ-013 SHALL implement FSM IDLE -> RESOLVE -> [SUB] -> DONE -> IDLE.
REQ-014 SHALL assert step_ready only in IDLE when clear=0 and resolve=0.
REQ-015 On accepted step SHALL set V <= (V+b_in+m_in)>>1 via 4:2 compression, single cycle, no carry propagation; bit 0 of the sum is discarded (caller guarantees even).
REQ-016 clear in IDLE SHALL zero S, Cy next cycle; clear wins over step and resolve; clear ignored outside IDLE.
REQ-017 resolve in IDLE (clear=0) SHALL enter RESOLVE; step same cycle not accepted.
REQ-018 RESOLVE SHALL add chunk k of S and Cy plus registered carry in cycle k, k=0..NCHUNK-1, LSB first, into R.
REQ-019 SUB (macro only) SHALL compute D=R-modulus chunkwise with registered borrow over NCHUNK cycles.
REQ-020 result SHALL be D if final borrow=0, else R[WIDTH:0]; without SUB, R[WIDTH:0].
REQ-021 res_valid SHALL rise 2*NCHUNK cycles (NCHUNK without macro) after the edge sampling resolve, and hold, with result stable, until res_ready.
REQ-022 On res_valid&&res_ready SHALL return to IDLE and zero S, Cy, R, D.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 R overflow beyond WIDTH+1 bits SHALL be truncated silently.

Reset
REQ-025 resetn=0 SHALL force IDLE, zero S, Cy, R, D, carry/borrow; step_ready=1 after release, res_valid=0, busy=0, result=0.
REQ-026 Reset mid-RESOLVE/SUB/DONE SHALL abort without emitting res_valid.

Configuration
REQ-027 Macro MP_CSA_ACC_FINAL_SUB_EN defined: SUB state and D register present, conditional subtraction per REQ-019/020.
REQ-028 Macro undefined: no SUB state, no D register, no modulus logic; modulus port present but unused.

Structure
REQ-029 Package mp_csa_pkg SHALL hold FSM state enum and NCHUNK computation function.
REQ-030 Sub-module csa4to2 SHALL implement one bitwise 4:2 compressor slice, instantiated per bit.

Verification
REQ-031 WIDTH=8,CHUNK=4, no macro: steps (b=6,m=0),(b=7,m=0), resolve -> res_valid after 3 cycles, result=5.
REQ-032 Same with macro, modulus=3 -> res_valid after 6 cycles, result=2; modulus=9 -> result=5.
REQ-033 WIDTH=512,CHUNK=128: 512 random steps vs. golden model, macro on -> res_valid after 10 cycles, result matches.
REQ-034 clear, step_valid, resolve all high in IDLE -> V=0, step_ready=0 that cycle, state stays IDLE.
REQ-035 res_ready low 5 cycles -> res_valid and result held constant; handshake -> IDLE, step_ready=1.
REQ-036 resetn low in cycle 2 of RESOLVE -> res_valid never asserts, busy=0, V=0.
